// File: rtl/end_screen_ctrl.sv
// Game-over screen sequencer: freeze, show with blinking prompts, commit a new
// high score, and issue exactly one restart/credit/attract request per game end.
module end_screen_ctrl #(
  parameter int FREEZE_FRAMES  = 30,
  parameter int BLINK_FRAMES   = 16,
  parameter int TIMEOUT_FRAMES = 900,
  parameter int SCORE_W        = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               gameOver,
  input  logic [SCORE_W-1:0] score,
  input  logic [SCORE_W-1:0] highScore,
  input  logic               keyStart,
  input  logic               keyCredit,
  output logic               endActive,
  output logic               newHighScore,
  output logic               promptVisible,
  output logic               hsWe,
  output logic [SCORE_W-1:0] hsData,
  output logic               restartReq,
  output logic               creditReq,
  output logic               attractReq
);

  localparam int MAX_FRAMES = (FREEZE_FRAMES > TIMEOUT_FRAMES) ? FREEZE_FRAMES : TIMEOUT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;
  localparam int BLK_W      = $clog2(BLINK_FRAMES) + 1;

  localparam logic [CNT_W-1:0] FREEZE_LAST  = CNT_W'(FREEZE_FRAMES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [BLK_W-1:0] BLINK_LAST   = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [BLK_W-1:0] BLK_ONE      = BLK_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FREEZE = 2'd1,
    SHOW   = 2'd2,
    EXIT   = 2'd3
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     frame_cnt_q;
  logic [BLK_W-1:0]     blink_cnt_q;
  logic                 hs_pend_q;
  logic                 key_start_q;
  logic                 key_start_prev_q;
  logic                 key_credit_q;
  logic                 key_credit_prev_q;
  logic                 end_active_q;
  logic                 new_hs_q;
  logic                 prompt_q;
  logic                 hs_we_q;
  logic [SCORE_W-1:0]   hs_data_q;
  logic                 restart_q;
  logic                 credit_q;
  logic                 attract_q;

  logic                 start_edge;
  logic                 credit_edge;
  logic                 timeout_hit;

  // Keys only count on a fresh press, so a key held since FREEZE never fires.
  assign start_edge  = key_start_q & ~key_start_prev_q;
  assign credit_edge = key_credit_q & ~key_credit_prev_q;
  assign timeout_hit = startOfFrame & (frame_cnt_q == TIMEOUT_LAST);

  // Key level sampling and edge history, tracked in every state.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      key_start_q       <= 1'b0;
      key_start_prev_q  <= 1'b0;
      key_credit_q      <= 1'b0;
      key_credit_prev_q <= 1'b0;
    end else begin
      key_start_q       <= keyStart;
      key_start_prev_q  <= key_start_q;
      key_credit_q      <= keyCredit;
      key_credit_prev_q <= key_credit_q;
    end
  end

  // Screen sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      blink_cnt_q  <= '0;
      hs_pend_q    <= 1'b0;
      end_active_q <= 1'b0;
      new_hs_q     <= 1'b0;
      prompt_q     <= 1'b0;
      hs_we_q      <= 1'b0;
      hs_data_q    <= '0;
      restart_q    <= 1'b0;
      credit_q     <= 1'b0;
      attract_q    <= 1'b0;
    end else begin
      hs_we_q   <= hs_pend_q & new_hs_q;
      hs_pend_q <= 1'b0;
      restart_q <= 1'b0;
      credit_q  <= 1'b0;
      attract_q <= 1'b0;
      case (state_q)
        IDLE: begin
          end_active_q <= 1'b0;
          prompt_q     <= 1'b0;
          if (gameOver) begin
            state_q      <= FREEZE;
            hs_data_q    <= score;
            new_hs_q     <= (score > highScore);
            frame_cnt_q  <= '0;
            hs_pend_q    <= 1'b1;
            end_active_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        FREEZE: begin
          end_active_q <= 1'b1;
          if (startOfFrame) begin
            if (frame_cnt_q == FREEZE_LAST) begin
              state_q     <= SHOW;
              frame_cnt_q <= '0;
              blink_cnt_q <= '0;
              prompt_q    <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + CNT_ONE;
            end
          end else begin
            frame_cnt_q <= frame_cnt_q;
          end
        end
        SHOW: begin
          if (startOfFrame) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_q <= '0;
              prompt_q    <= ~prompt_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + BLK_ONE;
            end
            if (frame_cnt_q != TIMEOUT_LAST) begin
              frame_cnt_q <= frame_cnt_q + CNT_ONE;
            end else begin
              frame_cnt_q <= frame_cnt_q;
            end
          end else begin
            blink_cnt_q <= blink_cnt_q;
          end
          // Start beats credit, and any key edge beats the timeout.
          if (start_edge || credit_edge || timeout_hit) begin
            state_q      <= EXIT;
            end_active_q <= 1'b0;
            prompt_q     <= 1'b0;
            new_hs_q     <= 1'b0;
            restart_q    <= start_edge;
            credit_q     <= ~start_edge & credit_edge;
            attract_q    <= ~start_edge & ~credit_edge;
          end else begin
            state_q <= SHOW;
          end
        end
        EXIT: begin
          state_q      <= IDLE;
          end_active_q <= 1'b0;
          prompt_q     <= 1'b0;
          new_hs_q     <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          end_active_q <= 1'b0;
          prompt_q     <= 1'b0;
          new_hs_q     <= 1'b0;
        end
      endcase
    end
  end

  assign endActive     = end_active_q;
  assign newHighScore  = new_hs_q;
  assign promptVisible = prompt_q;
  assign hsWe          = hs_we_q;
  assign hsData        = hs_data_q;
  assign restartReq    = restart_q;
  assign creditReq     = credit_q;
  assign attractReq    = attract_q;

endmodule
